// File: rtl/controlador_pkg.sv
// Shared constants for the controlador datapath sequencer:
// opcodes, FSM states and bus-select codes.
package pacote_processador;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [3:0] SEL_IMM  = 4'd8;
  localparam logic [3:0] SEL_G    = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd15;

endpackage

// File: rtl/controlador_if.sv
// Control-side bundle: start request and instruction in,
// datapath steering and status out.
interface controlador_if;
  logic       run;
  logic [8:0] instr;
  logic [3:0] sel;
  logic [7:0] r_en;
  logic       a_en;
  logic       g_en;
  logic       alu_sub;
  logic       done;
  logic       busy;

  modport master (
    output run, instr,
    input  sel, r_en, a_en, g_en, alu_sub, done, busy
  );

  modport slave (
    input  run, instr,
    output sel, r_en, a_en, g_en, alu_sub, done, busy
  );
endinterface

// File: rtl/controlador_dec.sv
// 3-to-8 one-hot decoder with enable, used for the
// register-file write strobes.
module decodificador3x8 (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);
  always_comb begin
    out = 8'b0;
    if (en) out[in] = 1'b1;
  end
endmodule

// File: rtl/controlador.sv
// Four-state sequencer for mv/mvi/add/sub; decodes only the
// latched IR so instr may change once captured.
module controlador
  import pacote_processador::*;
(
  input  logic clock,
  input  logic reset,
  controlador_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic [8:0] ir;
  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       wr;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= T0;
      ir    <= 9'd0;
    end else begin
      state <= state_nxt;
      if (state == T0 && bus.run) ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.sel     = SEL_NONE;
    bus.a_en    = 1'b0;
    bus.g_en    = 1'b0;
    bus.alu_sub = 1'b0;
    bus.done    = 1'b0;
    wr          = 1'b0;
    unique case (state)
      T0: if (bus.run) state_nxt = T1;
      T1: begin
        unique case (1'b1)
          (op == OP_MV): begin
            bus.sel   = {1'b0, ry};
            wr        = 1'b1;
            bus.done  = 1'b1;
            state_nxt = T0;
          end
          (op == OP_MVI): begin
            bus.sel   = SEL_IMM;
            wr        = 1'b1;
            bus.done  = 1'b1;
            state_nxt = T0;
          end
          (op == OP_ADD || op == OP_SUB): begin
            bus.sel   = {1'b0, rx};
            bus.a_en  = 1'b1;
            state_nxt = T2;
          end
          default: begin
            bus.done  = 1'b1;
            state_nxt = T0;
          end
        endcase
      end
      T2: begin
        bus.sel     = {1'b0, ry};
        bus.g_en    = 1'b1;
        bus.alu_sub = op[0];
        state_nxt   = T3;
      end
      T3: begin
        bus.sel   = SEL_G;
        wr        = 1'b1;
        bus.done  = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  assign bus.busy = (state != T0);

  decodificador3x8 u_dec (
    .in  (rx),
    .en  (wr),
    .out (bus.r_en)
  );

endmodule

// File: tb/tb_controlador.sv
// Directed vector bench for controlador: single-instruction
// table plus reset-abort, back-to-back and IR-hold sequences.
module tb_controlador;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] r_en;
    logic       a_en;
    logic       g_en;
    logic       alu_sub;
    logic       done;
    logic       busy;
  } exp_t;

  typedef struct {
    string      name;
    logic [8:0] instr;
    int         len;
    exp_t [2:0] e;
  } vec_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  controlador_if bus ();

  controlador dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [3:0] sel, input logic [7:0] r_en,
    input logic a, input logic g, input logic s,
    input logic d, input logic b);
    exp_t x;
    x.sel = sel; x.r_en = r_en; x.a_en = a;
    x.g_en = g; x.alu_sub = s; x.done = d; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input exp_t want);
    exp_t got;
    got.sel     = bus.sel;
    got.r_en    = bus.r_en;
    got.a_en    = bus.a_en;
    got.g_en    = bus.g_en;
    got.alu_sub = bus.alu_sub;
    got.done    = bus.done;
    got.busy    = bus.busy;
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got sel=%0d r_en=%b a=%b g=%b s=%b d=%b b=%b, want sel=%0d r_en=%b a=%b g=%b s=%b d=%b b=%b",
      name, got.sel, got.r_en, got.a_en, got.g_en, got.alu_sub,
      got.done, got.busy, want.sel, want.r_en, want.a_en,
      want.g_en, want.alu_sub, want.done, want.busy);
  endtask

  vec_t vq[$];
  exp_t idle;
  exp_t held[2:9];

  task automatic addv(input string n, input logic [8:0] i,
    input int l, input exp_t e0, input exp_t e1, input exp_t e2);
    vec_t v;
    v.name = n; v.instr = i; v.len = l;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    vq.push_back(v);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    idle   = mk(4'd15, 8'h00, 0, 0, 0, 0, 0);

    addv("mv_r3_r5", 9'b000_011_101, 1,
      mk(4'd5, 8'b0000_1000, 0, 0, 0, 1, 1), idle, idle);
    addv("mvi_r7", 9'b001_111_000, 1,
      mk(4'd8, 8'b1000_0000, 0, 0, 0, 1, 1), idle, idle);
    addv("sub_r2_r6", 9'b011_010_110, 3,
      mk(4'd2, 8'h00, 1, 0, 0, 0, 1),
      mk(4'd6, 8'h00, 0, 1, 1, 0, 1),
      mk(4'd9, 8'b0000_0100, 0, 0, 0, 1, 1));
    addv("add_r0_r0", 9'b010_000_000, 3,
      mk(4'd0, 8'h00, 1, 0, 0, 0, 1),
      mk(4'd0, 8'h00, 0, 1, 0, 0, 1),
      mk(4'd9, 8'b0000_0001, 0, 0, 0, 1, 1));
    addv("mv_r4_r4", 9'b000_100_100, 1,
      mk(4'd4, 8'b0001_0000, 0, 0, 0, 1, 1), idle, idle);
    addv("rsv_111", 9'b111_001_010, 1,
      mk(4'd15, 8'h00, 0, 0, 0, 1, 1), idle, idle);
    addv("mv_r0_r7", 9'b000_000_111, 1,
      mk(4'd7, 8'b0000_0001, 0, 0, 0, 1, 1), idle, idle);

    held[2] = mk(4'd1, 8'h00, 1, 0, 0, 0, 1);
    held[3] = mk(4'd2, 8'h00, 0, 1, 0, 0, 1);
    held[4] = mk(4'd9, 8'b0000_0010, 0, 0, 0, 1, 1);
    held[5] = idle;
    held[6] = mk(4'd1, 8'b0010_0000, 0, 0, 0, 1, 1);
    held[7] = idle;
    held[8] = mk(4'd15, 8'h00, 0, 0, 0, 1, 1);
    held[9] = idle;

    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.instr = 9'd0;
    #2;
    chk("reset_state", idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[n]) begin
      @(negedge clk);
      bus.instr = vq[n].instr;
      bus.run   = 1'b1;
      for (int i = 0; i < vq[n].len; i++) begin
        @(posedge clk);
        #1;
        if (i == 0) bus.run = 1'b0;
        chk($sformatf("%s_t%0d", vq[n].name, i + 1), vq[n].e[i]);
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s_idle", vq[n].name), idle);
    end

    // reset asserted between clock edges while in T2 of an add
    @(negedge clk);
    bus.instr = 9'b010_001_010;
    bus.run   = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pre_t2", mk(4'd2, 8'h00, 0, 1, 0, 0, 1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", idle);
    @(posedge clk);
    #1;
    chk("rst_held", idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_after1", idle);
    @(posedge clk);
    #1;
    chk("rst_after2", idle);

    // run held high: add, mv, reserved back to back
    @(negedge clk);
    bus.instr = 9'b010_001_010;
    bus.run   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held_c%0d", k + 1), held[k + 1]);
      if (k == 1) bus.instr = 9'b000_101_001;
      if (k == 5) bus.instr = 9'b101_011_001;
      if (k == 7) bus.run = 1'b0;
    end

    // instr changes after capture must not affect T3
    @(negedge clk);
    bus.instr = 9'b011_010_110;
    bus.run   = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    chk("irhold_t1", mk(4'd2, 8'h00, 1, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    bus.instr = 9'b000_111_001;
    chk("irhold_t2", mk(4'd6, 8'h00, 0, 1, 1, 0, 1));
    @(posedge clk);
    #1;
    chk("irhold_t3", mk(4'd9, 8'b0000_0100, 0, 0, 0, 1, 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/controlador.md
CONTROLADOR -- requirements
Module: controlador

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 run  input  1  start request, sampled only in state T0.
REQ-004 instr  input  9  instruction word {op[8:6], rx[5:3], ry[2:0]}.
REQ-005 sel  output  4  bus multiplexer select: 0-7 = r0-r7, 8 = immediate, 9 = ALU result register, 15 = bus undriven.
REQ-006 r_en  output  8  one-hot write enable for r0-r7.
REQ-007 a_en  output  1  load enable for ALU operand register A.
REQ-008 g_en  output  1  load enable for ALU result register.
REQ-009 alu_sub  output  1  ALU operation select: 0 = add, 1 = subtract.
REQ-010 done  output  1  one-cycle pulse in the final cycle of an instruction.
REQ-011 busy  output  1  high in any state other than T0.

Function
REQ-012 The FSM SHALL have four states: T0, T1, T2 and T3.
REQ-013 T0: when run=1, the FSM SHALL load instr into internal IR (9 bits) and go to T1; otherwise it SHALL stay in T0.
REQ-014 Decoding in T1-T3 SHALL use IR only; changes on instr after capture SHALL have no effect.
REQ-015 op 000 (mv): T1 drives sel=ry, r_en[rx]=1, done=1; next state T0; latency 2 cycles from run.
REQ-016 op 001 (mvi): T1 drives sel=8, r_en[rx]=1, done=1; next state T0.
REQ-017 op 010 (add) / 011 (sub): T1 drives sel=rx, a_en=1; next state T2.
REQ-018 add/sub in T2: sel=ry, g_en=1, alu_sub=op[0]; next state T3.
REQ-019 add/sub in T3: sel=9, r_en[rx]=1, done=1; next state T0; latency 4 cycles from run.
REQ-020 op 100-111 (reserved): T1 SHALL assert done=1 only, with no enables and sel=15; next state T0.
REQ-021 All outputs SHALL be combinational functions of state and IR; every output not driven in a state SHALL be 0, except sel, which SHALL be 15.
REQ-022 At most one bit of r_en SHALL be high in any cycle; r_en, a_en and g_en SHALL never be high in the same cycle.
REQ-023 rx=ry SHALL be legal: mv is a no-op write; add/sub use the same register as both operands.
REQ-024 run held high continuously SHALL start a new instruction in every T0 visit, with no idle cycle between instructions.
REQ-025 busy SHALL equal (state != T0).

Reset
REQ-026 On reset=1, state SHALL go to T0 and IR SHALL clear to 0 immediately, regardless of clock.
REQ-027 During reset: sel=15; r_en, a_en, g_en, alu_sub, done and busy SHALL all be 0.
REQ-028 Reset mid-instruction SHALL abort the instruction with no further register write; the first valid run is the first rising edge after reset deasserts.

Structure
REQ-029 Opcode constants, state encoding and sel constants (SEL_IMM=8, SEL_G=9, SEL_NONE=15) SHALL live in shared package pacote_processador.
REQ-030 The rx-to-r_en conversion SHALL be a sub-module decodificador3x8 (3-bit input, enable, 8-bit one-hot output).

Verification
REQ-031 instr=000_011_101 (mv r3,r5), run pulse: T1 shows sel=5, r_en=8'b00001000, done=1; busy returns to 0 on the next cycle.
REQ-032 instr=001_111_000 (mvi r7): T1 shows sel=8, r_en=8'b10000000, done=1.
REQ-033 instr=011_010_110 (sub r2,r6): T1 shows sel=2, a_en=1; T2 shows sel=6, g_en=1, alu_sub=1; T3 shows sel=9, r_en=8'b00000100, done=1.
REQ-034 Start add, then assert reset in T2: outputs go to their reset values asynchronously, state is T0, and no r_en pulse occurs.
REQ-035 run held at 1 with the sequence add, mv, reserved op 101: done pulses at cycles 4, 6 and 8, and the reserved op produces no enables.
REQ-036 Change instr during T2: the T3 outputs match the originally captured IR.
